// File: rtl/tdc_shot_sequencer_pkg.sv
// Shared types, defaults and helpers for the TDC shot sequencer.
package tdc_shot_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_ACK
  } state_t;

  localparam int DEF_PERIOD = 640;
  localparam int DEF_OFFSET = 10;
  localparam int MAX_CH     = 32;

  // Index of the first set bit at or after ptr, wrapping modulo n; -1 if mask is empty.
  function automatic int first_set_from(input logic [MAX_CH-1:0] mask, input int ptr, input int n);
    int found;
    int j;
    found = -1;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (ptr + k) % n;
        if (mask[j]) found = j;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/tdc_shot_sequencer_if.sv
// Configuration, frame handshake and start-pulse bundle of the shot sequencer.
interface tdc_shot_sequencer_if #(
  parameter int CNT_W  = 20,
  parameter int SHOT_W = 16,
  parameter int PW_W   = 8,
  parameter int N_CH   = 4
);
  logic              cfg_en;
  logic              cfg_cont;
  logic              cfg_rr;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_offset;
  logic [PW_W-1:0]   cfg_pulse_w;
  logic [SHOT_W-1:0] cfg_shots;
  logic [N_CH-1:0]   cfg_ch_mask;
  logic              frame_start;
  logic              frame_ack;
  logic [N_CH-1:0]   TDC_start;
  logic [SHOT_W-1:0] shot_idx;
  logic              frame_busy;
  logic              frame_done;
  logic              frame_abort;
  logic              err_cfg;

  modport master (
    output cfg_en, cfg_cont, cfg_rr, cfg_period, cfg_offset, cfg_pulse_w, cfg_shots, cfg_ch_mask,
    output frame_start, frame_ack,
    input  TDC_start, shot_idx, frame_busy, frame_done, frame_abort, err_cfg
  );

  modport slave (
    input  cfg_en, cfg_cont, cfg_rr, cfg_period, cfg_offset, cfg_pulse_w, cfg_shots, cfg_ch_mask,
    input  frame_start, frame_ack,
    output TDC_start, shot_idx, frame_busy, frame_done, frame_abort, err_cfg
  );
endinterface

// File: rtl/tdc_rr_pick.sv
// Combinational round-robin picker: next enabled channel at or after ptr, and the pointer past it.
module tdc_rr_pick
  import tdc_shot_sequencer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CH-1:0]  onehot,
  output logic [PTR_W-1:0] next_ptr
);
  logic [MAX_CH-1:0] mask_ext;
  int                idx;

  always_comb begin
    mask_ext               = '0;
    mask_ext[N_CH-1:0]     = mask;
    idx                    = first_set_from(mask_ext, int'(ptr), N_CH);
    onehot                 = '0;
    next_ptr               = ptr;
    if (idx >= 0) begin
      for (int i = 0; i < N_CH; i++) onehot[i] = (i == idx);
      next_ptr = PTR_W'((idx + 1) % N_CH);
    end
  end
endmodule

// File: rtl/tdc_shot_sequencer.sv
// TDC start generator: programmable shots per frame with offset/width/period,
// broadcast or round-robin channel selection and a frame done/ack handshake.
module tdc_shot_sequencer
  import tdc_shot_sequencer_pkg::*;
#(
  parameter int CNT_W  = 20,
  parameter int SHOT_W = 16,
  parameter int PW_W   = 8,
  parameter int N_CH   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  tdc_shot_sequencer_if.slave bus
);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, sh_period, sh_offset;
  logic [PW_W-1:0]   sh_pw, pw_eff;
  logic [SHOT_W-1:0] sh_shots, shot_idx;
  logic [N_CH-1:0]   sh_mask, start_q, start_next, rr_onehot;
  logic              sh_rr, sh_cont, first;
  logic [PTR_W-1:0]  rr_ptr, rr_next;
  logic [CNT_W:0]    cfg_end, win_end;
  logic              cfg_bad, wrap, last_wrap, in_win, load;
  logic              done_q, abort_q, err_q, done_next, abort_next, err_next;

  tdc_rr_pick #(.N_CH(N_CH), .PTR_W(PTR_W)) u_rr_pick (
    .mask     (sh_mask),
    .ptr      (rr_ptr),
    .onehot   (rr_onehot),
    .next_ptr (rr_next)
  );

  // Validation uses the live config; the sum is one bit wider so a large offset cannot wrap.
  always_comb begin
    pw_eff  = (bus.cfg_pulse_w == '0) ? PW_W'(1) : bus.cfg_pulse_w;
    cfg_end = {1'b0, bus.cfg_offset} + (CNT_W+1)'(pw_eff);
    cfg_bad = (bus.cfg_shots == '0) || (bus.cfg_ch_mask == '0) ||
              (cfg_end > {1'b0, bus.cfg_period});
  end

  // 'first' holds cnt at 0 for the cycle after a frame is (re)started.
  assign win_end   = {1'b0, sh_offset} + (CNT_W+1)'(sh_pw);
  assign in_win    = !first && (cnt >= sh_offset) && ({1'b0, cnt} < win_end);
  assign wrap      = (state == S_RUN) && !first && (cnt == sh_period);
  assign last_wrap = wrap && (shot_idx == sh_shots - SHOT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    done_next  = 1'b0;
    abort_next = 1'b0;
    err_next   = 1'b0;
    start_next = '0;
    case (state)
      S_IDLE: begin
        if (bus.cfg_en && bus.frame_start) begin
          if (cfg_bad) err_next = 1'b1;
          else begin
            load       = 1'b1;
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!bus.cfg_en) begin
          abort_next = 1'b1;
          state_next = S_IDLE;
        end else if (last_wrap) begin
          done_next = 1'b1;
          if (!sh_cont)            state_next = S_IDLE;
          else if (!bus.frame_ack) state_next = S_WAIT_ACK;
          else if (cfg_bad) begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end else begin
            load       = 1'b1;
            state_next = S_RUN;
          end
        end else if (in_win) begin
          start_next = sh_rr ? rr_onehot : sh_mask;
        end
      end
      S_WAIT_ACK: begin
        if (!bus.cfg_en) begin
          abort_next = 1'b1;
          state_next = S_IDLE;
        end else if (bus.frame_ack) begin
          if (cfg_bad) begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end else begin
            load       = 1'b1;
            state_next = S_RUN;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shadow config, counters, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      first     <= 1'b0;
      shot_idx  <= '0;
      sh_period <= '0;
      sh_offset <= '0;
      sh_pw     <= '0;
      sh_shots  <= '0;
      sh_mask   <= '0;
      sh_rr     <= 1'b0;
      sh_cont   <= 1'b0;
      rr_ptr    <= '0;
      start_q   <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_q <= start_next;
      done_q  <= done_next;
      abort_q <= abort_next;
      err_q   <= err_next;
      if (wrap && bus.cfg_en && sh_rr) rr_ptr <= rr_next;
      if (load) begin
        sh_period <= bus.cfg_period;
        sh_offset <= bus.cfg_offset;
        sh_pw     <= pw_eff;
        sh_shots  <= bus.cfg_shots;
        sh_mask   <= bus.cfg_ch_mask;
        sh_rr     <= bus.cfg_rr;
        if (state == S_IDLE) sh_cont <= bus.cfg_cont;
        cnt      <= '0;
        first    <= 1'b1;
        shot_idx <= '0;
      end else if ((state == S_RUN) && (state_next == S_RUN)) begin
        if (first) first <= 1'b0;
        else if (wrap) begin
          cnt      <= '0;
          shot_idx <= shot_idx + SHOT_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.TDC_start   = start_q;
  assign bus.shot_idx    = shot_idx;
  assign bus.frame_busy  = (state == S_RUN);
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
  assign bus.err_cfg     = err_q;
endmodule

// File: tb/tb_tdc_shot_sequencer.sv
// Directed bench for tdc_shot_sequencer: a config-acceptance table plus hand-written frame sequences.
module tb_tdc_shot_sequencer;
  import tdc_shot_sequencer_pkg::*;

  localparam int CNT_W  = 20;
  localparam int SHOT_W = 16;
  localparam int PW_W   = 8;
  localparam int N_CH   = 4;

  typedef struct packed {
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  offset;
    logic [PW_W-1:0]   pw;
    logic [SHOT_W-1:0] shots;
    logic [N_CH-1:0]   mask;
    logic              rr;
    logic              cont;
  } cfg_t;

  typedef struct packed {
    cfg_t cfg;
    logic exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #2 clk = ~clk;

  tdc_shot_sequencer_if #(.CNT_W(CNT_W), .SHOT_W(SHOT_W), .PW_W(PW_W), .N_CH(N_CH)) bus ();

  tdc_shot_sequencer #(.CNT_W(CNT_W), .SHOT_W(SHOT_W), .PW_W(PW_W), .N_CH(N_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int              vec_count = 0;
  int              miss_count = 0;
  int              last_done_at;
  int              last_done_cnt;
  logic [N_CH-1:0] shot_chan [16];
  vec_t            vecs [11];

  function automatic cfg_t mkCfg(input int period, input int offset, input int pw, input int shots,
                                 input int mask, input bit rr, input bit cont);
    cfg_t c;
    c.period = CNT_W'(period);
    c.offset = CNT_W'(offset);
    c.pw     = PW_W'(pw);
    c.shots  = SHOT_W'(shots);
    c.mask   = N_CH'(mask);
    c.rr     = rr;
    c.cont   = cont;
    return c;
  endfunction

  // Expected TDC_start in cycle n after the accepting edge, straight from the pulse timing formula.
  function automatic logic [N_CH-1:0] expStart(input int n, input cfg_t c);
    int k, s, r, pw, per;
    pw  = (c.pw == '0) ? 1 : int'(c.pw);
    per = int'(c.period) + 1;
    k   = n - 2;
    if (k < 0) return '0;
    s = k / per;
    r = k % per;
    if (s < int'(c.shots) && r >= int'(c.offset) && r < int'(c.offset) + pw)
      return c.rr ? shot_chan[s % 16] : c.mask;
    return '0;
  endfunction

  function automatic logic [31:0] outsWord();
    return 32'({bus.TDC_start, bus.shot_idx, bus.frame_busy, bus.frame_done, bus.frame_abort, bus.err_cfg});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input cfg_t c);
    bus.cfg_period  = c.period;
    bus.cfg_offset  = c.offset;
    bus.cfg_pulse_w = c.pw;
    bus.cfg_shots   = c.shots;
    bus.cfg_ch_mask = c.mask;
    bus.cfg_rr      = c.rr;
    bus.cfg_cont    = c.cont;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge that samples frame_start (cycle 0).
  task automatic startFrame(input cfg_t c);
    applyStimulus(c);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic abortFrame();
    bus.cfg_en = 1'b0;
    tick();
    bus.cfg_en = 1'b1;
  endtask

  task automatic watchCycles(input string tag, input cfg_t c, input int ncycles);
    int bad;
    bad = 0;
    last_done_at = -1;
    last_done_cnt = 0;
    for (int n = 1; n <= ncycles; n++) begin
      tick();
      if (bus.TDC_start !== expStart(n, c)) begin
        if (bad == 0) $display("[TB] %s: first start difference at cycle %0d (got %b, want %b)",
                               tag, n, bus.TDC_start, expStart(n, c));
        bad++;
      end
      if (bus.frame_done === 1'b1) begin
        last_done_at = n;
        last_done_cnt++;
      end
    end
    checkOutput({tag, "_start_pattern"}, bad, 0);
  endtask

  initial begin
    cfg_t c;
    int   bad;
    int   dones;

    bus.cfg_en = 1'b0; bus.cfg_cont = 1'b0; bus.cfg_rr = 1'b0;
    bus.cfg_period = '0; bus.cfg_offset = '0; bus.cfg_pulse_w = '0;
    bus.cfg_shots = '0; bus.cfg_ch_mask = '0;
    bus.frame_start = 1'b0; bus.frame_ack = 1'b0;
    for (int i = 0; i < 16; i++) shot_chan[i] = '0;

    vecs[0]  = '{cfg: mkCfg(640, 10, 1, 3, 4'b0001, 0, 0), exp_err: 1'b0};
    vecs[1]  = '{cfg: mkCfg(640, 639, 2, 3, 4'b0001, 0, 0), exp_err: 1'b1};
    vecs[2]  = '{cfg: mkCfg(640, 639, 1, 3, 4'b0001, 0, 0), exp_err: 1'b0};
    vecs[3]  = '{cfg: mkCfg(640, 639, 0, 3, 4'b0001, 0, 0), exp_err: 1'b0};
    vecs[4]  = '{cfg: mkCfg(640, 10, 1, 0, 4'b0001, 0, 0), exp_err: 1'b1};
    vecs[5]  = '{cfg: mkCfg(640, 10, 1, 3, 4'b0000, 0, 0), exp_err: 1'b1};
    vecs[6]  = '{cfg: mkCfg(640, 640, 1, 3, 4'b0001, 0, 0), exp_err: 1'b1};
    vecs[7]  = '{cfg: mkCfg(0, 0, 1, 1, 4'b0001, 0, 0), exp_err: 1'b1};
    vecs[8]  = '{cfg: mkCfg(1000, 0, 255, 2, 4'b1111, 0, 0), exp_err: 1'b0};
    vecs[9]  = '{cfg: mkCfg('hFFFFF, 'hFFFFF, 255, 1, 4'b0001, 0, 0), exp_err: 1'b1};
    vecs[10] = '{cfg: mkCfg('hFFFFF, 'hFFF00, 255, 1, 4'b0001, 0, 0), exp_err: 1'b0};

    #5;
    checkOutput("reset_outputs", outsWord(), 0);
    tick();
    rst_n = 1'b1;
    bus.cfg_en = 1'b1;
    tick();
    checkOutput("idle_after_reset", outsWord(), 0);

    // Acceptance table: rejected configs pulse err_cfg and stay idle; accepted ones start and are aborted.
    for (int i = 0; i < 11; i++) begin
      startFrame(vecs[i].cfg);
      checkOutput($sformatf("vec%0d_err", i), 32'(bus.err_cfg), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_busy", i), 32'(bus.frame_busy), 32'(!vecs[i].exp_err));
      if (vecs[i].exp_err) begin
        tick();
        checkOutput($sformatf("vec%0d_err_pulse", i), 32'({bus.err_cfg, bus.frame_busy}), 0);
      end else begin
        abortFrame();
        checkOutput($sformatf("vec%0d_abort", i), 32'({bus.frame_abort, bus.frame_busy}), 32'b10);
      end
    end
    tick();

    $display("[TB] broadcast single frame");
    c = mkCfg(DEF_PERIOD, DEF_OFFSET, 1, 3, 4'b0001, 0, 0);
    startFrame(c);
    checkOutput("s1_busy_c0", 32'({bus.frame_busy, bus.shot_idx}), 32'({1'b1, 16'd0}));
    watchCycles("s1", c, 1924);
    checkOutput("s1_done_cycle", last_done_at, 1924);
    checkOutput("s1_done_count", last_done_cnt, 1);
    checkOutput("s1_idle_hold_idx", 32'({bus.frame_busy, bus.shot_idx}), 32'({1'b0, 16'd2}));
    tick();
    checkOutput("s1_done_pulse", 32'(bus.frame_done), 0);

    $display("[TB] round-robin frame");
    c = mkCfg(100, 5, 3, 4, 4'b1010, 1, 0);
    shot_chan[0] = 4'b0010; shot_chan[1] = 4'b1000;
    shot_chan[2] = 4'b0010; shot_chan[3] = 4'b1000;
    startFrame(c);
    bus.cfg_ch_mask = 4'b0001;
    bus.cfg_offset  = '0;
    watchCycles("s2", c, 405);
    checkOutput("s2_done_cycle", last_done_at, 405);
    checkOutput("s2_last_idx", 32'(bus.shot_idx), 3);

    $display("[TB] continuous frames with ack");
    c = mkCfg(20, 3, 2, 2, 4'b0100, 0, 1);
    bus.frame_ack = 1'b0;
    startFrame(c);
    watchCycles("s3_f1", c, 43);
    checkOutput("s3_f1_done", last_done_at, 43);
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (bus.TDC_start !== '0 || bus.frame_busy !== 1'b0 || bus.frame_done !== 1'b0) bad++;
    end
    checkOutput("s3_wait_quiet", bad, 0);
    bus.frame_ack = 1'b1;
    tick();
    checkOutput("s3_restart", 32'({bus.frame_busy, bus.shot_idx}), 32'({1'b1, 16'd0}));
    watchCycles("s3_f2", c, 43);
    checkOutput("s3_f2_done", last_done_at, 43);
    checkOutput("s3_direct_restart", 32'({bus.frame_busy, bus.frame_done, bus.shot_idx}),
                32'({1'b1, 1'b1, 16'd0}));
    bus.frame_ack = 1'b0;
    watchCycles("s3_f3", c, 43);
    checkOutput("s3_f3_done", last_done_at, 43);
    checkOutput("s3_f3_wait", 32'(bus.frame_busy), 0);
    bus.cfg_shots = '0;
    bus.frame_ack = 1'b1;
    tick();
    checkOutput("s3_revalidate_err", 32'({bus.err_cfg, bus.frame_busy, bus.frame_abort}), 32'b100);
    bus.frame_ack = 1'b0;

    $display("[TB] abort mid-frame");
    c = mkCfg(DEF_PERIOD, DEF_OFFSET, 1, 3, 4'b0001, 0, 0);
    tick();
    startFrame(c);
    watchCycles("s4", c, 700);
    bus.cfg_en = 1'b0;
    tick();
    checkOutput("s4_abort", 32'({bus.frame_abort, bus.frame_busy, bus.TDC_start}), 32'({1'b1, 1'b0, 4'b0}));
    bus.cfg_en = 1'b1;
    bad = 0;
    dones = 0;
    for (int n = 0; n < 1300; n++) begin
      tick();
      if (bus.frame_done === 1'b1) dones++;
      if (bus.TDC_start !== '0 || bus.frame_abort !== 1'b0) bad++;
    end
    checkOutput("s4_no_done", dones, 0);
    checkOutput("s4_quiet", bad, 0);
    startFrame(c);
    checkOutput("s4_new_frame", 32'(bus.frame_busy), 1);
    abortFrame();

    $display("[TB] zero pulse width");
    c = mkCfg(20, 0, 0, 1, 4'b0001, 0, 0);
    tick();
    startFrame(c);
    watchCycles("s5d", c, 22);
    checkOutput("s5d_done", last_done_at, 22);

    $display("[TB] reset mid-frame");
    c = mkCfg(20, 2, 4, 3, 4'b1111, 1, 0);
    shot_chan[0] = 4'b0001; shot_chan[1] = 4'b0010; shot_chan[2] = 4'b0100;
    tick();
    startFrame(c);
    watchCycles("s6", c, 26);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_reset_async", outsWord(), 0);
    tick();
    tick();
    checkOutput("s6_reset_held", outsWord(), 0);
    rst_n = 1'b1;
    tick();
    checkOutput("s6_idle_release", outsWord(), 0);
    c = mkCfg(20, 2, 1, 1, 4'b1111, 1, 0);
    shot_chan[0] = 4'b0001;
    startFrame(c);
    watchCycles("s6_rr_ptr", c, 22);
    checkOutput("s6_done", last_done_at, 22);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end
endmodule
